action_scheduler: RTL

ACTION_SCHEDULER -- requirements
Module: action_scheduler

---
 rtl/action_scheduler.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/action_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : action_scheduler
// Description : Turns raw player buttons and a gravity timer into a stream of
//               one-hot game actions with a valid/ack handshake.
//               Each button is synchronised and edge-detected. A rising edge
//               sets that button's pending flag. A programmable gravity
//               counter sets its own pending "down" flag. A small FSM
//               (IDLE/RUN/ISSUE/HALT) chooses one pending action at a time
//               and holds it until the controller acknowledges it.
// Ports       :
//   clk          in   system clock (rising edge)
//   rst_n        in   asynchronous active-low reset
//   start        in   single-cycle pulse, starts or restarts a game
//   btn_right    in   raw asynchronous button, active-high
//   btn_left     in   raw asynchronous button, active-high
//   btn_down     in   raw asynchronous button, active-high
//   btn_rotate   in   raw asynchronous button, active-high
//   pause        in   level, freezes gravity and issuing
//   level [1:0]  in   speed level, gravity period = GRAV_BASE >> level
//   game_over    in   level, forces HALT
//   act_ack      in   controller accepts the presented action
//   act_valid    out  an action is presented
//   action [3:0] out  one-hot {rotate, right, left, down}
//   native_down  out  presented down came from gravity
//   grav_miss    out  one-cycle pulse, gravity tick lost
// Revision    : 1.0  initial release
// ============================================================================
module action_scheduler #(
    parameter int unsigned GRAV_BASE = 32'd12_500_000,
    parameter int          CW        = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_down,
    input  logic       btn_rotate,
    input  logic       pause,
    input  logic [1:0] level,
    input  logic       game_over,
    input  logic       act_ack,
    output logic       act_valid,
    output logic [3:0] action,
    output logic       native_down,
    output logic       grav_miss
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    // Bit positions shared by the button vectors and the action output.
    localparam int c_down  = 0;
    localparam int c_left  = 1;
    localparam int c_right = 2;
    localparam int c_rot   = 3;

    localparam logic [CW-1:0] c_grav_base = CW'(GRAV_BASE);

    state_t        r_state;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_prev;
    logic [3:0]    r_edge;
    logic [3:0]    r_pend;
    logic          r_pend_grav;
    logic [CW-1:0] r_cnt;
    logic          r_act_valid;
    logic [3:0]    r_action;
    logic          r_native;
    logic [3:0]    r_iss_user;
    logic          r_grav_miss;

    logic [3:0]    w_btn_raw;
    logic [CW-1:0] w_period;
    logic [CW-1:0] w_period_m1;
    logic          w_active;
    logic          w_run_en;
    logic          w_tick;
    logic          w_ack;
    logic [3:0]    w_set;
    logic [3:0]    w_clr_user;
    logic          w_clr_grav;
    logic [3:0]    w_pend_next;
    logic          w_grav_next;
    logic          w_miss;
    logic [CW-1:0] w_cnt_next;
    logic          w_any;
    logic [3:0]    w_arb_action;
    logic          w_arb_native;
    logic [3:0]    w_arb_iss;

    assign w_btn_raw = {btn_rotate, btn_right, btn_left, btn_down};

    always_comb begin
        w_period    = c_grav_base >> level;
        w_period_m1 = w_period - CW'(1);
        w_active    = (r_state == S_RUN) || (r_state == S_ISSUE);
        w_run_en    = w_active && !pause;
        // ">=" rather than "==" so that a level increase that leaves the
        // counter beyond the new period still produces a tick right away.
        w_tick      = w_run_en && (r_cnt >= w_period_m1);
        w_ack       = (r_state == S_ISSUE) && act_ack;

        // Simultaneous left and right cancel each other; edges are dropped
        // entirely outside an active, unpaused game.
        w_set = r_edge;
        if (r_edge[c_left] && r_edge[c_right]) begin
            w_set[c_left]  = 1'b0;
            w_set[c_right] = 1'b0;
        end
        if (!w_run_en) begin
            w_set = 4'b0000;
        end

        // Clearing only the flags that were actually issued lets a press
        // arriving during the wait survive the ack. A new edge in the ack
        // cycle re-sets its flag because the set term is ORed in last.
        w_clr_user  = w_ack ? r_iss_user : 4'b0000;
        w_clr_grav  = w_ack && r_native;
        w_pend_next = (r_pend & ~w_clr_user) | w_set;
        w_grav_next = (r_pend_grav && !w_clr_grav) || w_tick;
        w_miss      = w_tick && r_pend_grav && !w_clr_grav;

        w_cnt_next = r_cnt;
        if (w_run_en) begin
            w_cnt_next = w_tick ? '0 : r_cnt + CW'(1);
        end

        // Fixed priority: down (gravity or user) > rotate > left > right.
        w_any        = r_pend_grav || (|r_pend);
        w_arb_action = 4'b0000;
        w_arb_native = 1'b0;
        w_arb_iss    = 4'b0000;
        if (r_pend_grav || r_pend[c_down]) begin
            w_arb_action = 4'b0001;
            w_arb_native = r_pend_grav;
            w_arb_iss    = {3'b000, r_pend[c_down]};
        end else if (r_pend[c_rot]) begin
            w_arb_action = 4'b1000;
            w_arb_iss    = 4'b1000;
        end else if (r_pend[c_left]) begin
            w_arb_action = 4'b0010;
            w_arb_iss    = 4'b0010;
        end else if (r_pend[c_right]) begin
            w_arb_action = 4'b0100;
            w_arb_iss    = 4'b0100;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sync1     <= 4'b0000;
            r_sync2     <= 4'b0000;
            r_prev      <= 4'b0000;
            r_edge      <= 4'b0000;
            r_pend      <= 4'b0000;
            r_pend_grav <= 1'b0;
            r_cnt       <= '0;
            r_act_valid <= 1'b0;
            r_action    <= 4'b0000;
            r_native    <= 1'b0;
            r_iss_user  <= 4'b0000;
            r_grav_miss <= 1'b0;
        end else begin
            // Edge is registered so a detected edge lands in the pending
            // flags three edges after the button is first sampled.
            r_sync1     <= w_btn_raw;
            r_sync2     <= r_sync1;
            r_prev      <= r_sync2;
            r_edge      <= r_sync2 & ~r_prev;
            r_grav_miss <= 1'b0;

            if (game_over) begin
                r_state     <= S_HALT;
                r_act_valid <= 1'b0;
                r_action    <= 4'b0000;
                r_native    <= 1'b0;
                r_iss_user  <= 4'b0000;
                r_pend      <= 4'b0000;
                r_pend_grav <= 1'b0;
                r_cnt       <= '0;
            end else begin
                case (r_state)
                    S_IDLE, S_HALT: begin
                        if (start) begin
                            r_state     <= S_RUN;
                            r_cnt       <= '0;
                            r_pend      <= 4'b0000;
                            r_pend_grav <= 1'b0;
                            // Treat every button as already high so a
                            // button held across start must be released
                            // before it can register.
                            r_edge      <= 4'b0000;
                            r_prev      <= 4'b1111;
                        end
                    end
                    S_RUN: begin
                        r_pend      <= w_pend_next;
                        r_pend_grav <= w_grav_next;
                        r_cnt       <= w_cnt_next;
                        r_grav_miss <= w_miss;
                        if (!pause && w_any) begin
                            r_state     <= S_ISSUE;
                            r_act_valid <= 1'b1;
                            r_action    <= w_arb_action;
                            r_native    <= w_arb_native;
                            r_iss_user  <= w_arb_iss;
                        end
                    end
                    S_ISSUE: begin
                        r_pend      <= w_pend_next;
                        r_pend_grav <= w_grav_next;
                        r_cnt       <= w_cnt_next;
                        r_grav_miss <= w_miss;
                        if (w_ack) begin
                            r_state     <= S_RUN;
                            r_act_valid <= 1'b0;
                            r_action    <= 4'b0000;
                            r_native    <= 1'b0;
                            r_iss_user  <= 4'b0000;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign act_valid   = r_act_valid;
    assign action      = r_action;
    assign native_down = r_native;
    assign grav_miss   = r_grav_miss;

endmodule
`default_nettype wire
